// File: rtl/special_merge.sv
// FP16 sqrt result-assembly stage: resolves special operands directly, hands the rest to the sqrt core, holds the merged result under valid/ready.
// Optional watchdog on the core wait is enabled by defining SPECIAL_MERGE_TIMEOUT_EN.
module special_merge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        is_nan,
  input  logic        is_pinf,
  input  logic        is_ninf,
  input  logic        is_normal,
  input  logic        is_subnormal,
  input  logic        sign_in,
  input  logic [4:0]  exp_in,
  input  logic [9:0]  mant_in,
  output logic        core_start,
  output logic [4:0]  op_exp,
  output logic [9:0]  op_mant,
  input  logic        core_done,
  input  logic [4:0]  core_exp,
  input  logic [9:0]  core_mant,
  output logic        result_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [15:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        core_start_q, core_start_d;
  logic [4:0]  op_exp_q, op_exp_d;
  logic [9:0]  op_mant_q, op_mant_d;
  logic        timeout_err_q, timeout_err_d;

`ifdef SPECIAL_MERGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    op_exp_d      = op_exp_q;
    op_mant_d     = op_mant_q;
    core_start_d  = 1'b0;
    timeout_err_d = 1'b0;
`ifdef SPECIAL_MERGE_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    if (enable) begin
      case (state_q)
        IDLE: if (s_valid) begin
          state_d = HOLD;
          if (is_nan)       result_d = {sign_in, exp_in, mant_in};
          else if (is_ninf) result_d = 16'hFE00;
          else if (is_pinf) result_d = 16'h7C00;
          else if (!is_normal && !is_subnormal) result_d = {sign_in, 15'h0};
          else begin
            state_d      = WAIT;
            op_exp_d     = exp_in;
            op_mant_d    = mant_in;
            core_start_d = 1'b1;
`ifdef SPECIAL_MERGE_TIMEOUT_EN
            cnt_d        = '0;
`endif
          end
        end
        WAIT: begin
          // core_done beats a watchdog expiry landing on the same cycle
          if (core_done) begin
            state_d  = HOLD;
            result_d = {1'b0, core_exp, core_mant};
          end
`ifdef SPECIAL_MERGE_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_d       = HOLD;
            result_d      = 16'h7E00;
            timeout_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        HOLD: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    result_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      core_start_q   <= 1'b0;
      op_exp_q       <= '0;
      op_mant_q      <= '0;
      timeout_err_q  <= 1'b0;
`ifdef SPECIAL_MERGE_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      core_start_q   <= core_start_d;
      op_exp_q       <= op_exp_d;
      op_mant_q      <= op_mant_d;
      timeout_err_q  <= timeout_err_d;
`ifdef SPECIAL_MERGE_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  assign s_ready      = (state_q == IDLE);
  assign core_start   = core_start_q;
  assign op_exp       = op_exp_q;
  assign op_mant      = op_mant_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_special_merge.sv
// Self-checking bench for special_merge: directed corner steps plus randomized operands against a behavioural model.
module tb_special_merge;
  logic        clk = 1'b0;
  logic        rst_n, enable, s_valid, s_ready;
  logic        is_nan, is_pinf, is_ninf, is_normal, is_subnormal, sign_in;
  logic [4:0]  exp_in, op_exp, core_exp;
  logic [9:0]  mant_in, op_mant, core_mant;
  logic        core_start, core_done, result_valid, out_ready, timeout_err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  special_merge #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf), .is_normal(is_normal),
    .is_subnormal(is_subnormal), .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .core_start(core_start), .op_exp(op_exp), .op_mant(op_mant), .core_done(core_done),
    .core_exp(core_exp), .core_mant(core_mant), .result_valid(result_valid),
    .out_ready(out_ready), .result(result), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Reference: bit 16 set means the operand goes to the core; otherwise bits 15:0 are the final result.
  function automatic logic [16:0] ref_op(input logic [4:0] flags, input logic s,
                                         input logic [4:0] e, input logic [9:0] m);
    // flags = {nan, ninf, pinf, normal, subnormal}
    if (flags[4]) return {1'b0, s, e, m};
    if (flags[3]) return 17'h0FE00;
    if (flags[2]) return 17'h07C00;
    if (flags[1:0] == 2'b00) return {1'b0, s, 15'h0};
    return 17'h10000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [4:0] flags, input logic s, input logic [4:0] e, input logic [9:0] m);
    {is_nan, is_ninf, is_pinf, is_normal, is_subnormal} = flags;
    sign_in = s; exp_in = e; mant_in = m; s_valid = 1'b1;
  endtask

  task automatic idle_in();
    s_valid = 1'b0;
    {is_nan, is_ninf, is_pinf, is_normal, is_subnormal} = 5'b0;
  endtask

  task automatic release_hold(input logic [15:0] expv);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("release_rv", {15'h0, result_valid}, 16'h0);
    chk("release_srdy", {15'h0, s_ready}, 16'h1);
    chk("release_keep", result, expv);
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] expv;
    logic [4:0]  f, e, ce;
    logic [9:0]  m, cm;
    logic        s;
    int          d;

    rst_n = 1'b0; enable = 1'b1; out_ready = 1'b0; core_done = 1'b0;
    core_exp = '0; core_mant = '0; exp_in = '0; mant_in = '0; sign_in = 1'b0;
    idle_in();
    step(); step();
    chk("rst_rv", {15'h0, result_valid}, 16'h0);
    chk("rst_result", result, 16'h0000);
    chk("rst_srdy", {15'h0, s_ready}, 16'h1);
    chk("rst_start", {15'h0, core_start}, 16'h0);
    chk("rst_terr", {15'h0, timeout_err}, 16'h0);
    chk("rst_op", {1'b0, op_exp, op_mant}, 16'h0);
    rst_n = 1'b1;

    // Directed specials
    drive(5'b01000, 1'b1, 5'h1F, 10'h0); step(); idle_in();
    chk("ninf_rv", {15'h0, result_valid}, 16'h1);
    chk("ninf", result, 16'hFE00);
    chk("ninf_start", {15'h0, core_start}, 16'h0);
    step(); step();
    chk("ninf_held", result, 16'hFE00);
    release_hold(16'hFE00);
    drive(5'b00100, 1'b0, 5'h1F, 10'h0); step(); idle_in();
    chk("pinf", result, 16'h7C00);
    release_hold(16'h7C00);
    drive(5'b00000, 1'b1, 5'h00, 10'h0); step(); idle_in();
    chk("nzero", result, 16'h8000);
    release_hold(16'h8000);
    drive(5'b10000, 1'b0, 5'h1F, 10'h205); step(); idle_in();
    chk("nan", result, 16'h7E05);
    release_hold(16'h7E05);

    // Directed normal: core answers 5 cycles after accept
    drive(5'b00010, 1'b0, 5'h0F, 10'h000); step(); idle_in();
    chk("norm_start", {15'h0, core_start}, 16'h1);
    chk("norm_opexp", {11'h0, op_exp}, 16'h000F);
    chk("norm_rv0", {15'h0, result_valid}, 16'h0);
    step();
    chk("norm_start_pulse", {15'h0, core_start}, 16'h0);
    step(); step(); step();
    core_done = 1'b1; core_exp = 5'h0F; core_mant = 10'h0; step(); core_done = 1'b0;
    chk("norm_rv", {15'h0, result_valid}, 16'h1);
    chk("norm_result", result, 16'h3C00);

    // Backpressure then stall in HOLD with a pending operand upstream
    drive(5'b00100, 1'b0, 5'h1F, 10'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_result", result, 16'h3C00);
      chk("bp_rv", {15'h0, result_valid}, 16'h1);
      chk("bp_srdy", {15'h0, s_ready}, 16'h0);
    end
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_result", result, 16'h3C00);
      chk("stall_rv", {15'h0, result_valid}, 16'h1);
    end
    enable = 1'b1; step(); out_ready = 1'b0;
    chk("exit_rv", {15'h0, result_valid}, 16'h0);
    chk("exit_srdy", {15'h0, s_ready}, 16'h1);
    chk("exit_keep", result, 16'h3C00);
    step(); idle_in();
    chk("pending_acc", result, 16'h7C00);
    release_hold(16'h7C00);

    // Stalled accept is not honoured
    enable = 1'b0; drive(5'b01000, 1'b1, 5'h1F, 10'h0); step();
    chk("stall_acc_srdy", {15'h0, s_ready}, 16'h1);
    chk("stall_acc_rv", {15'h0, result_valid}, 16'h0);
    enable = 1'b1; step(); idle_in();
    chk("late_acc", result, 16'hFE00);
    release_hold(16'hFE00);

    // Stalled core_done in WAIT is ignored
    drive(5'b00001, 1'b0, 5'h00, 10'h155); step(); idle_in();
    enable = 1'b0; core_done = 1'b1; core_exp = 5'h05; core_mant = 10'h3AA; step();
    chk("stall_done_rv", {15'h0, result_valid}, 16'h0);
    chk("stall_start0", {15'h0, core_start}, 16'h0);
    enable = 1'b1; core_done = 1'b0; step();
    chk("wait_rv", {15'h0, result_valid}, 16'h0);
    core_done = 1'b1; step(); core_done = 1'b0;
    chk("sub_result", result, {1'b0, 5'h05, 10'h3AA});
    release_hold({1'b0, 5'h05, 10'h3AA});

    // Spurious core_done in IDLE
    core_done = 1'b1; core_exp = 5'h11; step(); core_done = 1'b0;
    chk("spur_srdy", {15'h0, s_ready}, 16'h1);
    chk("spur_rv", {15'h0, result_valid}, 16'h0);
    chk("spur_keep", result, {1'b0, 5'h05, 10'h3AA});

    // Randomized operands against the model
    for (int it = 0; it < 40; it++) begin
      f = 5'($urandom) & 5'($urandom);
      s = 1'($urandom); e = 5'($urandom); m = 10'($urandom);
      r = ref_op(f, s, e, m);
      drive(f, s, e, m); step(); idle_in();
      if (r[16]) begin
        chk("rnd_start", {15'h0, core_start}, 16'h1);
        chk("rnd_op", {1'b0, op_exp, op_mant}, {1'b0, e, m});
        d = $urandom_range(1, 6);
        for (int k = 1; k < d; k++) begin
          step();
          chk("rnd_wait_rv", {15'h0, result_valid}, 16'h0);
        end
        ce = 5'($urandom); cm = 10'($urandom);
        core_done = 1'b1; core_exp = ce; core_mant = cm; step(); core_done = 1'b0;
        expv = {1'b0, ce, cm};
      end else begin
        chk("rnd_nostart", {15'h0, core_start}, 16'h0);
        expv = r[15:0];
      end
      chk("rnd_rv", {15'h0, result_valid}, 16'h1);
      chk("rnd_result", result, expv);
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        step();
        chk("rnd_hold", result, expv);
      end
      release_hold(expv);
    end

    // Reset while waiting on the core abandons the operation
    drive(5'b00010, 1'b0, 5'h10, 10'h001); step(); idle_in();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    core_done = 1'b1; core_exp = 5'h0A; step(); core_done = 1'b0;
    chk("rstw_srdy", {15'h0, s_ready}, 16'h1);
    chk("rstw_rv", {15'h0, result_valid}, 16'h0);
    chk("rstw_result", result, 16'h0000);
    chk("rstw_op", {1'b0, op_exp, op_mant}, 16'h0);

`ifdef SPECIAL_MERGE_TIMEOUT_EN
    // Watchdog: fires on the 8th enabled WAIT cycle; stalled cycles do not count
    drive(5'b00010, 1'b0, 5'h0F, 10'h0); step(); idle_in();
    for (int k = 1; k < 8; k++) begin
      if (k == 4) begin
        enable = 1'b0; step(); step(); enable = 1'b1;
        chk("to_stall_terr", {15'h0, timeout_err}, 16'h0);
      end
      step();
      chk("to_rv0", {15'h0, result_valid}, 16'h0);
      chk("to_terr0", {15'h0, timeout_err}, 16'h0);
    end
    step();
    chk("to_terr", {15'h0, timeout_err}, 16'h1);
    chk("to_rv", {15'h0, result_valid}, 16'h1);
    chk("to_result", result, 16'h7E00);
    step();
    chk("to_pulse", {15'h0, timeout_err}, 16'h0);
    release_hold(16'h7E00);
    drive(5'b00010, 1'b0, 5'h0F, 10'h0); step(); idle_in();
    for (int k = 1; k < 8; k++) step();
    core_done = 1'b1; core_exp = 5'h0F; core_mant = 10'h123; step(); core_done = 1'b0;
    chk("to_race_terr", {15'h0, timeout_err}, 16'h0);
    chk("to_race_result", result, {1'b0, 5'h0F, 10'h123});
    release_hold({1'b0, 5'h0F, 10'h123});
`else
    // Without the watchdog the wait is unbounded
    drive(5'b00010, 1'b0, 5'h0F, 10'h0); step(); idle_in();
    for (int k = 0; k < 20; k++) begin
      step();
      chk("nowd_rv", {15'h0, result_valid}, 16'h0);
      chk("nowd_terr", {15'h0, timeout_err}, 16'h0);
    end
    core_done = 1'b1; core_exp = 5'h0E; core_mant = 10'h2D4; step(); core_done = 1'b0;
    chk("nowd_result", result, {1'b0, 5'h0E, 10'h2D4});
    release_hold({1'b0, 5'h0E, 10'h2D4});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
